// File: rtl/s_term_loopback_bist.sv
`default_nettype none
// ============================================================================
// Module : s_term_loopback_bist
// South termination: bit-reversed loopback onto north wires, or LFSR BIST.
// Rev    : 1.0
// ============================================================================
module s_term_loopback_bist #(
   parameter int          W1     = 4,
   parameter int          W2     = 8,
   parameter int          W4     = 16,
   parameter int          PIPE   = 0,
   parameter int          RT_LAT = 2,
   parameter logic [15:0] SEED   = 16'hACE1
) (
   input  logic          UserCLK,
   input  logic          reset,
   input  logic [W1-1:0] S1END,
   input  logic [W2-1:0] S2MID,
   input  logic [W2-1:0] S2END,
   input  logic [W4-1:0] S4END,
   output logic [W1-1:0] N1BEG,
   output logic [W2-1:0] N2BEG,
   output logic [W2-1:0] N2BEGb,
   output logic [W4-1:0] N4BEG,
   input  logic          bist_en,
   input  logic          bist_start,
   input  logic [15:0]   bist_len,
   output logic          bist_busy,
   output logic          bist_done,
   output logic          bist_pass,
   output logic [15:0]   bist_err_cnt
);
   localparam int          N       = W1 + 2*W2 + W4;
   localparam logic [23:0] RT      = 24'(RT_LAT);
   localparam logic [1:0]  ST_IDLE = 2'd0;
   localparam logic [1:0]  ST_RUN  = 2'd1;
   localparam logic [1:0]  ST_DONE = 2'd2;

   function automatic logic [15:0] lfsr_next(input logic [15:0] s);
      return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
   endfunction

   logic [1:0]   state_q, state_d;
   logic [23:0]  cyc_q, cyc_d;
   logic [15:0]  len_q, len_d;
   logic [15:0]  g_q, g_d;
   logic [15:0]  c_q, c_d;
   logic [15:0]  err_q, err_d;
   logic         done_q, done_d;
   logic         pass_q, pass_d;
   logic [N-1:0] nout_q, nout_d;

   logic [N-1:0] lb_d, lb_out, south, gen_pat, chk_pat;
   logic [15:0]  gen_src;
   logic [23:0]  last_cyc;

   assign south    = {S4END, S2END, S2MID, S1END};
   // The start edge loads the first word straight from SEED.
   assign gen_src  = (state_q == ST_RUN) ? g_q : SEED;
   assign last_cyc = {8'd0, len_q} + RT - 24'd1;

   generate
      for (genvar j = 0; j < N; j++) begin : g_pat
         assign gen_pat[j] = gen_src[j % 16];
         assign chk_pat[j] = c_q[j % 16];
      end
      for (genvar i = 0; i < W1; i++) begin : g_rev1
         assign lb_d[i] = S1END[W1-1-i];
      end
      for (genvar i = 0; i < W2; i++) begin : g_rev2
         assign lb_d[W1+i]    = S2MID[W2-1-i];
         assign lb_d[W1+W2+i] = S2END[W2-1-i];
      end
      for (genvar i = 0; i < W4; i++) begin : g_rev4
         assign lb_d[W1+2*W2+i] = S4END[W4-1-i];
      end
      if (PIPE != 0) begin : g_pipe
         logic [N-1:0] lb_q;
         always_ff @(posedge UserCLK or posedge reset) begin
            if (reset) lb_q <= '0;
            else       lb_q <= lb_d;
         end
         assign lb_out = lb_q;
      end else begin : g_comb
         assign lb_out = lb_d;
      end
   endgenerate

   always_ff @(posedge UserCLK or posedge reset) begin
      if (reset) begin
         state_q <= ST_IDLE;
         cyc_q   <= '0;
         len_q   <= '0;
         g_q     <= SEED;
         c_q     <= SEED;
         err_q   <= '0;
         done_q  <= 1'b0;
         pass_q  <= 1'b0;
         nout_q  <= '0;
      end else begin
         state_q <= state_d;
         cyc_q   <= cyc_d;
         len_q   <= len_d;
         g_q     <= g_d;
         c_q     <= c_d;
         err_q   <= err_d;
         done_q  <= done_d;
         pass_q  <= pass_d;
         nout_q  <= nout_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cyc_d   = cyc_q;
      len_d   = len_q;
      g_d     = g_q;
      c_d     = c_q;
      err_d   = err_q;
      done_d  = done_q;
      pass_d  = pass_q;
      nout_d  = '0;
      if (!bist_en) begin
         state_d = ST_IDLE;
         done_d  = 1'b0;
         pass_d  = 1'b0;
      end else begin
         case (state_q)
            ST_RUN: begin
               cyc_d = cyc_q + 24'd1;
               if ((cyc_q + 24'd1) < {8'd0, len_q}) begin
                  nout_d = gen_pat;
                  g_d    = lfsr_next(g_q);
               end
               // cyc_q >= RT, phrased to stay non-constant when RT is zero
               if ((cyc_q + 24'd1) > RT) begin
                  if (south != chk_pat && err_q != 16'hFFFF) err_d = err_q + 16'd1;
                  c_d = lfsr_next(c_q);
               end
               if (cyc_q == last_cyc) begin
                  state_d = ST_DONE;
                  done_d  = 1'b1;
                  pass_d  = (err_d == 16'd0);
               end
            end
            default: begin
               if (bist_start) begin
                  cyc_d = '0;
                  len_d = bist_len;
                  c_d   = SEED;
                  err_d = '0;
                  g_d   = SEED;
                  if (bist_len == 16'd0) begin
                     state_d = ST_DONE;
                     done_d  = 1'b1;
                     pass_d  = 1'b1;
                  end else begin
                     state_d = ST_RUN;
                     done_d  = 1'b0;
                     pass_d  = 1'b0;
                     nout_d  = gen_pat;
                     g_d     = lfsr_next(SEED);
                  end
               end
            end
         endcase
      end
   end

   always_comb begin
      bist_busy    = (state_q == ST_RUN);
      bist_done    = done_q;
      bist_pass    = pass_q;
      bist_err_cnt = err_q;
      {N4BEG, N2BEGb, N2BEG, N1BEG} = bist_en ? nout_q : lb_out;
   end
endmodule
`default_nettype wire
